// File: rtl/serializer_pkg.sv
// Shared defaults, state encoding and elaboration helpers for the word-to-slice serializer.
package serializer_pkg;

    localparam int unsigned DEF_IN_W     = 32;
    localparam int unsigned DEF_OUT_W    = 8;
    localparam int unsigned DEF_DEPTH    = 4;
    localparam logic [7:0]  DEF_IDLE_SYM = 8'hBC;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/serializer_param_if.sv
// Upstream word handshake and downstream slice handshake of the serializer.
interface serializer_param_if
    import serializer_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W
);

    logic [IN_W-1:0]  data_in;
    logic             valid_in;
    logic             ready_in;
    logic [OUT_W-1:0] data_out;
    logic             valid_out;
    logic             ready_out;

    modport slave (
        input  data_in,
        input  valid_in,
        input  ready_out,
        output ready_in,
        output data_out,
        output valid_out
    );

    modport master (
        output data_in,
        output valid_in,
        output ready_out,
        input  ready_in,
        input  data_out,
        input  valid_out
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and registered occupancy flags.
module sync_fifo
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_IN_W,
    parameter int unsigned DEPTH = DEF_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_c_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses writes even when a pop happens in the same cycle.
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_c_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign count_o   = count_q;

endmodule

// File: rtl/serializer_param.sv
// Buffers IN_W-bit words in a FIFO and emits them as RATIO registered OUT_W-bit slices.
module serializer_param
    import serializer_pkg::*;
#(
    parameter int unsigned      IN_W      = DEF_IN_W,
    parameter int unsigned      OUT_W     = DEF_OUT_W,
    parameter int unsigned      DEPTH     = DEF_DEPTH,
    parameter bit               MSB_FIRST = 1'b1,
    parameter logic [OUT_W-1:0] IDLE_SYM  = OUT_W'(DEF_IDLE_SYM)
) (
    input logic              clk_4f,
    input logic              reset,
    serializer_param_if.slave bus
);

    localparam int unsigned RATIO    = IN_W / OUT_W;
    localparam int unsigned IDX_W    = $clog2(RATIO);
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if (((IN_W % OUT_W) != 0) || (RATIO < 2)) begin : g_bad_ratio
        $error("serializer_param: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
    end
    if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
        $error("serializer_param: DEPTH must be a power of two and at least 2");
    end

    ser_state_e       state_q;
    ser_state_e       state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [IN_W-1:0]  shreg_q;
    logic [IN_W-1:0]  shreg_d;
    logic [OUT_W-1:0] data_out_q;
    logic [OUT_W-1:0] data_out_d;
    logic             valid_out_q;
    logic             valid_out_d;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [IN_W-1:0]  fifo_head;
    logic             load_head;
    logic             xfer;
    logic             unused_full;

    sync_fifo #(
        .WIDTH (IN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_4f),
        .reset     (reset),
        .push_i    (bus.valid_in),
        .pop_i     (fifo_pop),
        .wdata_i   (bus.data_in),
        .rdata_c_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign unused_full = fifo_full;

    // The slice to emit always sits at the leading end of the shift register.
    function automatic logic [OUT_W-1:0] lead_slice(input logic [IN_W-1:0] w);
        return MSB_FIRST ? w[IN_W-1 -: OUT_W] : w[OUT_W-1:0];
    endfunction

    function automatic logic [IN_W-1:0] drop_slice(input logic [IN_W-1:0] w);
        return MSB_FIRST ? (w << OUT_W) : (w >> OUT_W);
    endfunction

    assign xfer = valid_out_q && bus.ready_out;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        fifo_pop    = 1'b0;
        load_head   = 1'b0;

        case (state_q)
            ST_IDLE: load_head = !fifo_empty;
            ST_SHIFT: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        if (!fifo_empty) begin
                            load_head = 1'b1;
                        end else begin
                            state_d     = ST_IDLE;
                            idx_d       = '0;
                            valid_out_d = 1'b0;
                            data_out_d  = IDLE_SYM;
                        end
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        shreg_d    = drop_slice(shreg_q);
                        data_out_d = lead_slice(shreg_d);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Loading on the final-slice edge keeps back-to-back words gap-free.
        if (load_head) begin
            fifo_pop    = 1'b1;
            state_d     = ST_SHIFT;
            idx_d       = '0;
            shreg_d     = fifo_head;
            data_out_d  = lead_slice(fifo_head);
            valid_out_d = 1'b1;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            shreg_q     <= '0;
            data_out_q  <= IDLE_SYM;
            valid_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // ready_in depends only on FIFO occupancy, never on the current pop.
    assign bus.ready_in  = (fifo_count != CNT_W'(DEPTH));
    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;

endmodule

// File: tb/tb_serializer_param.sv
// Directed and random checks of three serializer configurations against a slice-queue model.
module tb_serializer_param;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [15:0] qa [$];
    logic [15:0] qb [$];
    logic [15:0] qc [$];

    localparam logic [7:0]  E035  [4]  = '{8'hFF, 8'hFB, 8'hBF, 8'hFF};
    localparam logic [7:0]  E036  [4]  = '{8'h03, 8'h00, 8'h00, 8'hDD};
    localparam logic [15:0] E040  [4]  = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    localparam logic [31:0] BURST [3]  = '{32'hFFFBBFFF, 32'hDDDDDDDD, 32'hAAAAAAAA};
    localparam logic [7:0]  E037  [12] = '{8'hFF, 8'hFB, 8'hBF, 8'hFF, 8'hDD, 8'hDD,
                                           8'hDD, 8'hDD, 8'hAA, 8'hAA, 8'hAA, 8'hAA};

    always #5 clk = ~clk;

    serializer_param_if #(.IN_W(32), .OUT_W(8))  ia ();
    serializer_param_if #(.IN_W(32), .OUT_W(8))  ib ();
    serializer_param_if #(.IN_W(64), .OUT_W(16)) ic ();

    serializer_param #(.IN_W(32), .OUT_W(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_SYM(8'hBC))
        u_a (.clk_4f(clk), .reset(rst), .bus(ia.slave));
    serializer_param #(.IN_W(32), .OUT_W(8), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_SYM(8'hBC))
        u_b (.clk_4f(clk), .reset(rst), .bus(ib.slave));
    serializer_param #(.IN_W(64), .OUT_W(16), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_SYM(16'h00BC))
        u_c (.clk_4f(clk), .reset(rst), .bus(ic.slave));

    // Slice i of a word by plain shift arithmetic.
    function automatic logic [15:0] mslice(input logic [63:0] w, input int iw, input int ow,
                                           input bit msb, input int i);
        int          sh;
        logic [63:0] mask;
        sh   = msb ? (iw / ow - 1 - i) * ow : i * ow;
        mask = (64'd1 << ow) - 64'd1;
        return 16'((w >> sh) & mask);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int which, input logic [63:0] w);
        for (int i = 0; i < 4; i++) begin
            case (which)
                0:       qa.push_back(mslice(w, 32, 8, 1'b1, i));
                1:       qb.push_back(mslice(w, 32, 8, 1'b0, i));
                default: qc.push_back(mslice(w, 64, 16, 1'b1, i));
            endcase
        end
    endtask

    task automatic sb_pop(input string tag, input int which, input logic [15:0] obs);
        int          n;
        logic [15:0] exp;
        n = (which == 0) ? qa.size() : (which == 1) ? qb.size() : qc.size();
        checks++;
        assert (n > 0) else begin
            errors++;
            $error("FAIL %s_extra: observed slice %0h, expected no slice", tag, obs);
        end
        if (n > 0) begin
            case (which)
                0:       exp = qa.pop_front();
                1:       exp = qb.pop_front();
                default: exp = qc.pop_front();
            endcase
            check(tag, 64'(obs), 64'(exp));
        end
    endtask

    // Model the handshakes seen before the edge, advance one cycle, check the idle symbol.
    task automatic tick();
        if (rst) begin
            qa.delete();
            qb.delete();
            qc.delete();
        end else begin
            if (ia.valid_in && ia.ready_in)   sb_push(0, 64'(ia.data_in));
            if (ib.valid_in && ib.ready_in)   sb_push(1, 64'(ib.data_in));
            if (ic.valid_in && ic.ready_in)   sb_push(2, ic.data_in);
            if (ia.valid_out && ia.ready_out) sb_pop("sb_a", 0, 16'(ia.data_out));
            if (ib.valid_out && ib.ready_out) sb_pop("sb_b", 1, 16'(ib.data_out));
            if (ic.valid_out && ic.ready_out) sb_pop("sb_c", 2, ic.data_out);
        end
        @(posedge clk);
        #1;
        if (!ia.valid_out) check("idle_sym_a", 64'(ia.data_out), 64'h00BC);
        if (!ib.valid_out) check("idle_sym_b", 64'(ib.data_out), 64'h00BC);
        if (!ic.valid_out) check("idle_sym_c", 64'(ic.data_out), 64'h00BC);
    endtask

    initial begin
        logic [31:0] w6 [6];
        logic        acc6;

        rst = 1'b1;
        ia.valid_in = 1'b0; ia.data_in = '0; ia.ready_out = 1'b0;
        ib.valid_in = 1'b0; ib.data_in = '0; ib.ready_out = 1'b0;
        ic.valid_in = 1'b0; ic.data_in = '0; ic.ready_out = 1'b0;
        ia.valid_in = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ia.valid_in = 1'b0;
        check("rst_valid_a", 64'(ia.valid_out), 64'h0);
        check("rst_data_a",  64'(ia.data_out),  64'hBC);
        check("rst_ready_a", 64'(ia.ready_in),  64'h1);
        check("rst_valid_b", 64'(ib.valid_out), 64'h0);
        check("rst_ready_b", 64'(ib.ready_in),  64'h1);
        check("rst_valid_c", 64'(ic.valid_out), 64'h0);
        check("rst_data_c",  64'(ic.data_out),  64'hBC);
        check("rst_ready_c", 64'(ic.ready_in),  64'h1);

        // Single word, MSB first, with one-edge latency from acceptance.
        ia.ready_out = 1'b1;
        ia.data_in   = 32'hFFFBBFFF;
        ia.valid_in  = 1'b1;
        tick();
        ia.valid_in = 1'b0;
        check("latency_a", 64'(ia.valid_out), 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("single_valid_a", 64'(ia.valid_out), 64'h1);
            check("single_data_a",  64'(ia.data_out),  64'(E035[i]));
        end
        tick();
        check("single_end_a", 64'(ia.valid_out), 64'h0);

        // LSB-first and wide-slice configurations in parallel.
        ib.ready_out = 1'b1; ib.data_in = 32'hDD000003;          ib.valid_in = 1'b1;
        ic.ready_out = 1'b1; ic.data_in = 64'h0123456789ABCDEF;  ic.valid_in = 1'b1;
        tick();
        ib.valid_in = 1'b0;
        ic.valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lsb_data_b",  64'(ib.data_out), 64'(E036[i]));
            check("wide_data_c", ic.data_out,      64'(E040[i]));
        end
        tick();
        check("lsb_end_b",  64'(ib.valid_out), 64'h0);
        check("wide_end_c", 64'(ic.valid_out), 64'h0);

        // Back-to-back words stream without a bubble.
        for (int t = 0; t < 14; t++) begin
            if (t < 3) begin
                ia.valid_in = 1'b1;
                ia.data_in  = BURST[t];
            end else begin
                ia.valid_in = 1'b0;
            end
            tick();
            if (t >= 1 && t < 13) begin
                check("burst_valid_a", 64'(ia.valid_out), 64'h1);
                check("burst_data_a",  64'(ia.data_out),  64'(E037[t-1]));
            end else if (t == 13) begin
                check("burst_end_a", 64'(ia.valid_out), 64'h0);
            end
        end

        // Reset in the middle of a word with two more queued.
        ia.data_in = 32'hDDDDDDDD; ia.valid_in = 1'b1;
        tick();
        ia.data_in = 32'h11111111;
        tick();
        check("mid_slice0_a", 64'(ia.data_out), 64'hDD);
        ia.data_in = 32'h22222222;
        tick();
        check("mid_slice1_a", 64'(ia.data_out), 64'hDD);
        ia.valid_in = 1'b0;
        rst = 1'b1;
        ia.valid_in = 1'b1;
        tick();
        rst = 1'b0;
        ia.valid_in = 1'b0;
        check("mid_rst_valid_a", 64'(ia.valid_out), 64'h0);
        check("mid_rst_data_a",  64'(ia.data_out),  64'hBC);
        check("mid_rst_ready_a", 64'(ia.ready_in),  64'h1);
        for (int t = 0; t < 8; t++) begin
            tick();
            check("no_stale_a", 64'(ia.valid_out), 64'h0);
        end

        // Stalled downstream: FIFO plus shift register hold five words.
        ia.ready_out = 1'b0;
        for (int i = 0; i < 6; i++) w6[i] = $urandom;
        for (int i = 0; i < 5; i++) begin
            ia.data_in  = w6[i];
            ia.valid_in = 1'b1;
            check("fill_ready_a", 64'(ia.ready_in), 64'h1);
            tick();
        end
        ia.data_in = w6[5];
        check("full_ready_a", 64'(ia.ready_in), 64'h0);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid_a", 64'(ia.valid_out), 64'h1);
            check("hold_data_a",  64'(ia.data_out),  64'(mslice(64'(w6[0]), 32, 8, 1'b1, 0)));
            tick();
        end
        ia.ready_out = 1'b1;
        acc6 = 1'b0;
        for (int t = 0; t < 80 && !(acc6 && qa.size() == 0); t++) begin
            if (ia.valid_in && ia.ready_in) acc6 = 1'b1;
            tick();
            if (acc6) ia.valid_in = 1'b0;
        end
        check("retry6_accepted_a", 64'(acc6), 64'h1);
        check("drain_empty_a",     64'(qa.size()), 64'h0);
        check("drain_valid_a",     64'(ia.valid_out), 64'h0);

        // Random traffic on all three instances.
        for (int t = 0; t < 400; t++) begin
            ia.valid_in = 1'($urandom_range(0, 1)); ia.data_in = $urandom;
            ib.valid_in = 1'($urandom_range(0, 1)); ib.data_in = $urandom;
            ic.valid_in = 1'($urandom_range(0, 1)); ic.data_in = {$urandom, $urandom};
            ia.ready_out = ($urandom_range(0, 3) != 0);
            ib.ready_out = ($urandom_range(0, 3) != 0);
            ic.ready_out = ($urandom_range(0, 1) != 0);
            tick();
        end
        ia.valid_in = 1'b0; ib.valid_in = 1'b0; ic.valid_in = 1'b0;
        ia.ready_out = 1'b1; ib.ready_out = 1'b1; ic.ready_out = 1'b1;
        for (int t = 0; t < 200 && (qa.size() + qb.size() + qc.size()) != 0; t++) tick();
        tick();
        check("rand_drain_a", 64'(qa.size()), 64'h0);
        check("rand_drain_b", 64'(qb.size()), 64'h0);
        check("rand_drain_c", 64'(qc.size()), 64'h0);
        check("rand_idle_a",  64'(ia.valid_out), 64'h0);
        check("rand_idle_c",  64'(ic.valid_out), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serializer_param.md
SERIALIZER_PARAM -- requirements
Module: serializer_param

Interface
REQ-001 Parameter IN_W, default 32, input word width in bits.
REQ-002 Parameter OUT_W, default 8, output slice width; IN_W SHALL be an integer multiple of OUT_W, RATIO = IN_W/OUT_W >= 2.
REQ-003 Parameter DEPTH, default 4, input FIFO depth in words; power of two, >= 2.
REQ-004 Parameter MSB_FIRST, default 1, slice order: 1 = most-significant slice first, 0 = least-significant first.
REQ-005 Parameter IDLE_SYM, default 8'hBC (width OUT_W), value driven on data_out when no valid slice.
REQ-006 clk_4f  input  1  single clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 data_in  input  IN_W  parallel word.
REQ-009 valid_in  input  1  data_in valid.
REQ-010 ready_in  output  1  block can accept a word this cycle.
REQ-011 data_out  output  OUT_W  serial slice.
REQ-012 valid_out  output  1  data_out carries a slice.
REQ-013 ready_out  input  1  downstream accepts slice this cycle.

Function
REQ-014 Word accepted on rising edge when valid_in && ready_in; written into FIFO.
REQ-015 ready_in = !fifo_full, combinational from FIFO count only; no same-cycle write when full even if a pop occurs.
REQ-016 Slice transfer occurs on rising edge when valid_out && ready_out; slice index then advances.
REQ-017 Serializer states: IDLE (no word held) and SHIFT (word held, slice index 0..RATIO-1).
REQ-018 IDLE -> SHIFT: FIFO non-empty; head popped and loaded into shift register, index = 0.
REQ-019 SHIFT, transfer of slice RATIO-1, FIFO non-empty: next head loaded same edge, no bubble cycle.
REQ-020 SHIFT, transfer of slice RATIO-1, FIFO empty: -> IDLE.
REQ-021 ready_out low: data_out, valid_out and index hold unchanged.
REQ-022 Latency: word accepted at edge k into empty block -> first slice on data_out with valid_out=1 after edge k+1.
REQ-023 Throughput: ready_out held high and FIFO never empty -> valid_out continuously 1, one word per RATIO cycles.
REQ-024 Slice i (MSB_FIRST=1) = data_in[IN_W-1-i*OUT_W -: OUT_W]; MSB_FIRST=0 -> data_in[i*OUT_W +: OUT_W].
REQ-025 data_out and valid_out registered; valid_out=0 implies data_out=IDLE_SYM.
REQ-026 Simultaneous FIFO push and pop SHALL keep count unchanged and preserve order.
REQ-027 FIFO pointers wrap modulo DEPTH; count range 0..DEPTH.

Reset
REQ-028 While reset is high at an edge: FIFO emptied, pointers/count 0, state IDLE, index 0.
REQ-029 Reset values: valid_out=0, data_out=IDLE_SYM, ready_in=1 from the first cycle after reset.
REQ-030 Reset mid-word discards partially sent word and all queued words; no remaining slice emitted afterward.
REQ-031 valid_in during a reset cycle is ignored.

Structure
REQ-032 Package serializer_pkg holds default IN_W, OUT_W, DEPTH, IDLE_SYM and state encoding constants.
REQ-033 Sub-module sync_fifo (WIDTH, DEPTH parameters, push/pop/full/empty/count) instantiated once; serializer FSM and shift register in top.
REQ-034 Elaboration-time check on IN_W % OUT_W == 0 and DEPTH power of two.

Verification
REQ-035 Defaults, ready_out=1, single word 32'hFFFBBFFF -> data_out FF,FB,BF,FF on 4 consecutive cycles, then BC with valid_out=0.
REQ-036 MSB_FIRST=0, word 32'hDD000003 -> 03,00,00,DD.
REQ-037 Back-to-back FFFBBFFF, DDDDDDDD, AAAAAAAA -> 12 contiguous valid slices FF,FB,BF,FF,DD,DD,DD,DD,AA,AA,AA,AA, no gap.
REQ-038 ready_out=0 throughout, push 6 words -> ready_in drops after 5 accepted (4 FIFO + 1 shift), data_out holds first slice; release -> all 5 words emitted in order, 6th retried.
REQ-039 Reset asserted after second slice of DDDDDDDD with 2 words queued -> next cycle valid_out=0, data_out=BC, ready_in=1, no stale slice ever.
REQ-040 IN_W=64, OUT_W=16, word 64'h0123456789ABCDEF -> 0123,4567,89AB,CDEF.
